// File: rtl/song_beat_counter.sv
`default_nettype none
// ============================================================================
// Module   : song_beat_counter
// Purpose  : Divides the system clock down to the song's beat rate and
//            advances an 8-bit song position. The game FSM controls it with
//            start, pause and stop pulses. The counter output feeds the
//            progress bar, and the beat pulse paces note fetch.
// Ports    : clk      - system clock (rising edge)
//            reset_n  - synchronous active-low reset
//            start    - pulse: begin playback from position 0
//            pause    - pulse: toggle PLAYING <-> PAUSED
//            stop     - pulse: abort to IDLE (highest priority)
//            counter  - registered song position, 0..SONG_LEN-1
//            beat     - registered one-cycle pulse per beat boundary
//            playing  - high while in PLAYING
//            done     - high while in DONE
// Options  : SONG_LOOP_EN - when defined, the song wraps to position 0 at the
//            final beat and keeps playing; DONE is never entered.
// Revision : 1.0 - initial release
// ============================================================================
module song_beat_counter #(
    parameter int CLK_DIV  = 25_000_000,
    parameter int SONG_LEN = 90
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    output logic [7:0] counter,
    output logic       beat,
    output logic       playing,
    output logic       done
);

    localparam int               PRE_W    = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [7:0]       CNT_LAST = 8'(SONG_LEN - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAYING = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PRE_W-1:0] pre_q,   pre_d;
    logic [7:0]       cnt_q,   cnt_d;
    logic             beat_q,  beat_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            cnt_q   <= '0;
            beat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state logic; stop overrides every other input, including a
    // terminal count landing on the same edge.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        beat_d  = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            pre_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pre_d = '0;
                    cnt_d = '0;
                    if (start) begin
                        state_d = ST_PLAYING;
                    end
                end
                ST_PLAYING: begin
                    // A pause edge freezes everything, so a beat that would
                    // have fired is deferred until counting resumes.
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (pre_q == PRE_LAST) begin
                        pre_d  = '0;
                        beat_d = 1'b1;
                        if (cnt_q < CNT_LAST) begin
                            cnt_d = cnt_q + 8'd1;
                        end else begin
`ifdef SONG_LOOP_EN
                            cnt_d = '0;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end else begin
                        pre_d = pre_q + PRE_ONE;
                    end
                end
                ST_PAUSED: begin
                    if (pause) begin
                        state_d = ST_PLAYING;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_d = ST_PLAYING;
                        pre_d   = '0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pre_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs decode straight from registers, so they are glitch-free
    always_comb begin
        counter = cnt_q;
        beat    = beat_q;
        playing = (state_q == ST_PLAYING);
`ifdef SONG_LOOP_EN
        done    = 1'b0;
`else
        done    = (state_q == ST_DONE);
`endif
    end

endmodule
`default_nettype wire

// File: doc/song_beat_counter.md
# song_beat_counter

Beat-rate song position counter for the guitar-game datapath. Divides the system clock down to the song's beat rate and advances an 8-bit song position, with start, pause and stop control from the game FSM. Sits directly upstream of the progress-bar stage: its `counter` output drives the progress bar's 8-bit counter input, and its `beat` pulse paces the note-fetch logic.

## Interface
- `CLK_DIV`, default 25_000_000: clock cycles per beat; must be ≥ 2.
- `SONG_LEN`, default 90: number of beats in the song; range 1..256.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins playback from position 0.
- `pause`  in  1  single-cycle pulse; toggles between PLAYING and PAUSED.
- `stop`  in  1  single-cycle pulse; aborts to IDLE.
- `counter`  out  8  current song position, 0..SONG_LEN-1; registered.
- `beat`  out  1  one-cycle pulse on each beat boundary; registered.
- `playing`  out  1  high while in PLAYING.
- `done`  out  1  high while in DONE.

## Operation
- State machine states: IDLE, PLAYING, PAUSED, DONE.
- Internal prescaler width is `$clog2(CLK_DIV)`. It counts 0..CLK_DIV-1.
- Input priority on any edge: `stop` > `start` > `pause`.
- IDLE:
  - `counter`=0 and prescaler=0.
  - `start` moves to PLAYING. Prescaler and counter stay 0 on that edge.
- PLAYING:
  - On each edge with no control input, the prescaler increments.
  - When the prescaler is at CLK_DIV-1, it returns to 0 and `beat`=1 for the following cycle.
  - On that same beat edge, if `counter` < SONG_LEN-1, `counter` increments.
  - Otherwise `counter` holds at SONG_LEN-1 and the state moves to DONE. The final beat still pulses.
- PAUSED:
  - Prescaler and `counter` are frozen. `beat`=0.
  - `pause` returns to PLAYING. No increment happens on the resume edge.
- On an edge where `pause` is sampled in PLAYING, the prescaler and counter hold and no beat is issued, even at terminal count. The deferred beat occurs on the first counting edge after resume.
- DONE:
  - `done`=1 and `counter` holds.
  - `start` moves to PLAYING with counter=0 and prescaler=0.
- `stop` in any state: next state IDLE, counter=0, prescaler=0, `beat`=0. `stop` wins over a simultaneous terminal count.
- Ignored inputs: `start` in PLAYING or PAUSED; `pause` in IDLE or DONE.
- Song length in PLAYING cycles is exactly SONG_LEN×CLK_DIV.

## Timing
- Reset (`reset_n` low at an edge) forces: state IDLE, `counter`=0, prescaler=0, `beat`=0, `playing`=0, `done`=0. All other inputs are ignored that edge.
- A reset asserted mid-song discards all progress.
- All outputs are registered. Each control input takes effect on the edge at which it is sampled, so outputs reflect it in the next cycle.
- If `start` is sampled at edge t0, then:
  - `playing`=1 from t0.
  - `beat` is high in the cycles after edges t0+k·CLK_DIV, for k=1..SONG_LEN.
  - `counter`=k after edge t0+k·CLK_DIV, for k < SONG_LEN.
- `done` rises on the same edge as the final `beat`; `playing` falls on that edge.

## Configuration
- `SONG_LOOP_EN` defined:
  - At the final beat, `counter` wraps to 0 and the state stays PLAYING.
  - DONE is unreachable and `done` is tied to 0.
  - `beat` continues to pulse every CLK_DIV cycles.
- `SONG_LOOP_EN` undefined: DONE behaviour as in Operation.

## Test plan
All scenarios use CLK_DIV=4, SONG_LEN=5.
- Full song: release reset, pulse `start` at t0.
  - `beat` is high after edges t0+4, +8, +12, +16, +20.
  - `counter` reads 1, 2, 3, 4, 4.
  - After t0+20: `done`=1, `playing`=0; `counter` stays 4 indefinitely.
- Pause: in PLAYING with prescaler=2, pulse `pause`, hold 10 cycles, then pulse `pause` again at edge r.
  - No `beat` during the pause and `counter` unchanged.
  - Next `beat` after edge r+2.
- Stop: in PLAYING with `counter`=3, pulse `stop` together with `start`.
  - Next cycle: IDLE, `counter`=0, `playing`=0, `beat`=0.
- Restart: in DONE, pulse `start`.
  - `done`=0, `playing`=1, `counter`=0.
  - First `beat` 4 edges later, with `counter`=1.
- Reset: drive `reset_n` low at `counter`=3 while pulsing `start`.
  - All outputs 0 the next cycle and state IDLE.
  - `start` pulsed after release restarts normally.
- With `SONG_LOOP_EN`: after the 5th beat `counter`=0, `playing`=1, `done`=0; the 6th beat gives `counter`=1.
